kmp_sequencer: RTL and testbench

Control sequencer for the KMP string-search datapath. On `start` it copies the pattern from the pattern ROM into local registers, builds the KMP prefix (LPS) table, then scans the text ROM. On a mismatch it falls back through the LPS table instead of resetting the pattern pointer. It drives both ROM address buses directly, reports every match position, keeps a saturating match count, and pulses `done` at end of text.

---
 rtl/kmp_sequencer.sv | 153 +++++++++++++++
 tb/tb_kmp_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/kmp_sequencer.sv
// KMP search sequencer: loads the pattern, builds the LPS table, then scans text ROM reporting matches.
// Optional macro KMP_SEQ_EARLY_EXIT_EN: stop the scan at the first match.
module kmp_sequencer #(
  parameter int PAT_LEN = 4,
  parameter int PAT_AW  = 3,
  parameter int TXT_LEN = 55,
  parameter int TXT_AW  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [7:0]        pat_data,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [7:0]        txt_data,
  output logic              busy,
  output logic              done,
  output logic              match_valid,
  output logic [TXT_AW-1:0] match_pos,
  output logic [CNT_W-1:0]  match_count
);
  // Index width covers 0..PAT_LEN so k can reach its terminal value.
  localparam int KW = $clog2(PAT_LEN + 1);
  localparam int PD = 1 << KW;
  localparam logic [KW-1:0]     K_LAST = KW'(PAT_LEN - 1);
  localparam logic [KW-1:0]     K_END  = KW'(PAT_LEN);
  localparam logic [TXT_AW-1:0] I_LAST = TXT_AW'(TXT_LEN - 1);
  localparam logic [TXT_AW-1:0] P_OFS  = TXT_AW'(PAT_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUILD, S_FETCH, S_CMP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        pat [PD];
  logic [KW-1:0]     lps [PD];
  logic [KW-1:0]     ld_cnt, len, k, j;
  logic [TXT_AW-1:0] i;
  logic              done_q;

  logic bld_eq, bld_end, cmp_eq, cmp_full, i_step, i_end;

  assign bld_eq   = (pat[k] == pat[len]);
  assign bld_end  = (bld_eq || len == '0) && (k == K_LAST);
  assign cmp_eq   = (pat[j] == txt_data);
  assign cmp_full = cmp_eq && (j == K_LAST);
  assign i_step   = cmp_eq || (j == '0);
  assign i_end    = (i == I_LAST);

  assign pat_addr = PAT_AW'(ld_cnt);
  assign txt_addr = i;
  // done is registered off the DONE state so it never coincides with a final match pulse.
  assign done     = done_q;
  assign busy     = (state != S_IDLE) || done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (ld_cnt == K_END) state_nxt = S_BUILD;
      S_BUILD: if (bld_end) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_CMP;
      S_CMP: begin
        if (i_step) state_nxt = i_end ? S_DONE : S_FETCH;
`ifdef KMP_SEQ_EARLY_EXIT_EN
        if (cmp_full) state_nxt = S_DONE;
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt      <= '0;
      len         <= '0;
      k           <= '0;
      j           <= '0;
      i           <= '0;
      done_q      <= 1'b0;
      match_valid <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
      for (int q = 0; q < PD; q++) begin
        pat[q] <= '0;
        lps[q] <= '0;
      end
    end else begin
      match_valid <= 1'b0;
      done_q      <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            match_count <= '0;
            match_pos   <= '0;
            ld_cnt      <= '0;
            i           <= '0;
          end
        end
        S_LOAD: begin
          // ROM data lags its address by one cycle, so capture the previous slot.
          if (ld_cnt != '0) pat[ld_cnt - 1'b1] <= pat_data;
          if (ld_cnt == K_END) begin
            ld_cnt <= '0;
            len    <= '0;
            k      <= KW'(1);
            lps[0] <= '0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        S_BUILD: begin
          if (bld_eq) begin
            lps[k] <= len + 1'b1;
            len    <= len + 1'b1;
            k      <= k + 1'b1;
          end else if (len != '0) begin
            len <= lps[len - 1'b1];
          end else begin
            lps[k] <= '0;
            k      <= k + 1'b1;
          end
          if (bld_end) begin
            i <= '0;
            j <= '0;
          end
        end
        S_CMP: begin
          if (cmp_full) begin
            match_valid <= 1'b1;
            match_pos   <= i - P_OFS;
            if (match_count != '1) match_count <= match_count + 1'b1;
            j <= lps[K_LAST];
            i <= i + 1'b1;
          end else if (cmp_eq) begin
            j <= j + 1'b1;
            i <= i + 1'b1;
          end else if (j != '0) begin
            j <= lps[j - 1'b1];
          end else begin
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kmp_sequencer.sv
// Randomised and directed bench for kmp_sequencer against a brute-force string-match model.
module tb_kmp_sequencer;
  localparam int PAT_LEN = 4;
  localparam int TXT_LEN = 55;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] pat_addr, pat_addr_s;
  logic [7:0] pat_data, txt_data;
  logic [7:0] txt_addr, txt_addr_s;
  logic       busy, done, match_valid;
  logic       busy_s, done_s, match_valid_s;
  logic [7:0] match_pos, match_pos_s;
  logic [7:0] match_count;
  logic [3:0] match_count_s;

  logic [7:0] pat_rom [8];
  logic [7:0] txt_rom [256];

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pat_data <= pat_rom[pat_addr];
    txt_data <= txt_rom[txt_addr];
  end

  kmp_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .pat_addr(pat_addr), .pat_data(pat_data),
    .txt_addr(txt_addr), .txt_data(txt_data),
    .busy(busy), .done(done), .match_valid(match_valid),
    .match_pos(match_pos), .match_count(match_count)
  );

  // Narrow-counter twin runs in lockstep to exercise saturation.
  kmp_sequencer #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .pat_addr(pat_addr_s), .pat_data(pat_data),
    .txt_addr(txt_addr_s), .txt_data(txt_data),
    .busy(busy_s), .done(done_s), .match_valid(match_valid_s),
    .match_pos(match_pos_s), .match_count(match_count_s)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pat(input string s);
    for (int c = 0; c < 8; c++) pat_rom[c] = (c < s.len()) ? s[c] : 8'h00;
  endtask

  task automatic set_txt(input string s, input logic [7:0] fill);
    for (int c = 0; c < 256; c++) txt_rom[c] = (c < s.len()) ? s[c] : fill;
  endtask

  // Naive reference: try every alignment directly.
  task automatic build_expect();
    bit ok;
    exp_q.delete();
    for (int p = 0; p <= TXT_LEN - PAT_LEN; p++) begin
      ok = 1'b1;
      for (int c = 0; c < PAT_LEN; c++) if (txt_rom[p + c] != pat_rom[c]) ok = 1'b0;
`ifdef KMP_SEQ_EARLY_EXIT_EN
      if (ok && exp_q.size() == 0) exp_q.push_back(p);
`else
      if (ok) exp_q.push_back(p);
`endif
    end
  endtask

  // Longest proper prefix of pat[0..q] that is also its suffix.
  function automatic int lps_ref(input int q);
    int best = 0;
    bit ok;
    for (int l = 1; l <= q; l++) begin
      ok = 1'b1;
      for (int c = 0; c < l; c++) if (pat_rom[c] != pat_rom[q - l + 1 + c]) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  task automatic do_run(input string tag, input int exp_cyc, input bit poke_start);
    int  cyc = 0;
    int  nmv = 0;
    int  busy_low = 0;
    int  mv_cyc = -1;
    bit  got_done = 1'b0;
    int  n_exp;
    build_expect();
    n_exp = exp_q.size();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (poke_start && cyc == 30);
      if (match_valid) begin
        if (nmv < n_exp) check_eq({tag, " pos"}, match_pos, exp_q[nmv]);
        else check_eq({tag, " extra match"}, nmv, n_exp);
        check_eq({tag, " mv with done"}, done, 0);
        nmv++;
        mv_cyc = cyc;
      end
      if (!busy) busy_low++;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, " done seen"}, got_done, 1);
    check_eq({tag, " pulses"}, nmv, n_exp);
    check_eq({tag, " count"}, match_count, (n_exp > 255) ? 255 : n_exp);
    check_eq({tag, " sat count"}, match_count_s, (n_exp > 15) ? 15 : n_exp);
    check_eq({tag, " busy gaps"}, busy_low, 0);
    if (exp_cyc > 0) check_eq({tag, " latency"}, cyc, exp_cyc);
`ifdef KMP_SEQ_EARLY_EXIT_EN
    if (n_exp > 0) check_eq({tag, " done after mv"}, cyc, mv_cyc + 1);
`endif
    if (n_exp > 0) check_eq({tag, " last pos held"}, match_pos, exp_q[n_exp - 1]);
    for (int q = 0; q < PAT_LEN; q++) check_eq({tag, " lps"}, dut.lps[q], lps_ref(q));
    @(negedge clk);
    check_eq({tag, " done width"}, done, 0);
    check_eq({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    string p, t;
    rst = 1'b1;
    start = 1'b0;
    set_pat("ABAB");
    set_txt("", 8'h78);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst mv", match_valid, 0);
    check_eq("rst pos", match_pos, 0);
    check_eq("rst count", match_count, 0);
    check_eq("rst pat_addr", pat_addr, 0);
    check_eq("rst txt_addr", txt_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    set_pat("ABAB"); set_txt("ABABAB", 8'h78);
    do_run("abab", -1, 1'b0);

`ifdef KMP_SEQ_EARLY_EXIT_EN
    set_pat("AAAA"); set_txt("", 8'h41);
    do_run("aaaa", -1, 1'b1);
`else
    set_pat("AAAA"); set_txt("", 8'h41);
    do_run("aaaa", 120, 1'b1);
`endif

    set_pat("ABCD"); set_txt("", 8'h5A);
    do_run("abcd", 120, 1'b0);

    set_pat("AABA"); set_txt("AAABAABA", 8'h78);
    do_run("aaba", -1, 1'b0);

    // Reset in the middle of the scan, then rerun.
    set_pat("AAAA"); set_txt("", 8'h41);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("mid rst busy", busy, 0);
    check_eq("mid rst done", done, 0);
    check_eq("mid rst mv", match_valid, 0);
    check_eq("mid rst pos", match_pos, 0);
    check_eq("mid rst count", match_count, 0);
    check_eq("mid rst txt_addr", txt_addr, 0);
    @(negedge clk);
    do_run("rerun", -1, 1'b0);

    for (int r = 0; r < 15; r++) begin
      p = ""; t = "";
      for (int c = 0; c < PAT_LEN; c++) pat_rom[c] = 8'h41 + 8'($urandom_range(0, 1));
      for (int c = 0; c < 256; c++) txt_rom[c] = 8'h41 + 8'($urandom_range(0, 1));
      do_run($sformatf("rand%0d", r), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
